// File: rtl/sonar_trigger_seq.sv
// ---------------------------------------------------------------------------
// sonar_trigger_seq
//
// Measurement sequencer for an ultrasonic ranging sensor. It sits directly
// upstream of the echo-timing stage. For each attempt it:
//   1. raises the sensor trigger for TRIG_CYCLES cycles,
//   2. waits up to ECHO_TIMEOUT cycles for the echo-timing stage to report
//      that the echo rose (triggerSuc),
//   3. waits up to MEAS_TIMEOUT cycles for a finished distance (valid),
//   4. idles for HOLDOFF_CYCLES cycles so that echoes from this ping die out
//      before the next one is sent.
// Lost or absent echoes end the attempt with a timeout pulse. A saturating
// error counter keeps track of the timeouts.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   enable      level; high = run measurements back to back
//   triggerSuc  1-cycle pulse from the echo-timing stage: echo rose
//   valid       1-cycle pulse from the echo-timing stage: distance valid
//   distance    echo width in cycles, sampled when valid = 1
//   trigger     sensor trigger line (registered)
//   meas_valid  1-cycle pulse: meas_dist was just updated
//   meas_dist   last captured distance, held until the next capture
//   timeout     1-cycle pulse: the current attempt failed
//   err_count   saturating count of timeouts
//   busy        high in any state other than IDLE
//   seq_state   state encoding: IDLE=0 TRIG=1 WAIT_ECHO=2 MEASURE=3 HOLDOFF=4
// ---------------------------------------------------------------------------
module sonar_trigger_seq #(
   parameter int DisLen         = 16,
   parameter int TRIG_CYCLES    = 500,
   parameter int ECHO_TIMEOUT   = 1500000,
   parameter int MEAS_TIMEOUT   = 131088,
   parameter int HOLDOFF_CYCLES = 2500000,
   parameter int CNT_W          = 22
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              triggerSuc,
   input  logic              valid,
   input  logic [DisLen:0]   distance,
   output logic              trigger,
   output logic              meas_valid,
   output logic [DisLen:0]   meas_dist,
   output logic              timeout,
   output logic [7:0]        err_count,
   output logic              busy,
   output logic [2:0]        seq_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TRIG      = 3'd1,
      S_WAIT_ECHO = 3'd2,
      S_MEASURE   = 3'd3,
      S_HOLDOFF   = 3'd4
   } state_t;

   // Terminal counts: the counter starts at 0 on state entry, so the last
   // cycle of an N-cycle interval is the one with count N-1.
   localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'(MEAS_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              trigger_q, trigger_d;
   logic              meas_valid_q, meas_valid_d;
   logic [DisLen:0]   meas_dist_q, meas_dist_d;
   logic              timeout_q, timeout_d;
   logic [7:0]        err_count_q, err_count_d;

   // Next-state and next-output logic.
   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      meas_valid_d = 1'b0;
      timeout_d    = 1'b0;
      meas_dist_d  = meas_dist_q;

      unique case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_TRIG;
         end

         S_TRIG: begin
            // triggerSuc / valid are deliberately ignored while pinging.
            if (cnt_q == TRIG_LAST) state_d = S_WAIT_ECHO;
         end

         S_WAIT_ECHO: begin
            // Echo start takes priority over a coincident timeout.
            if (triggerSuc) begin
               state_d = S_MEASURE;
            end else if (cnt_q == ECHO_LAST) begin
               state_d   = S_HOLDOFF;
               timeout_d = 1'b1;
            end
         end

         S_MEASURE: begin
            // A result takes priority over a coincident timeout. The timeout
            // also covers an echo stage that saturates without reporting.
            if (valid) begin
               state_d      = S_HOLDOFF;
               meas_dist_d  = distance;
               meas_valid_d = 1'b1;
            end else if (cnt_q == MEAS_LAST) begin
               state_d   = S_HOLDOFF;
               timeout_d = 1'b1;
            end
         end

         S_HOLDOFF: begin
            // Always runs to completion regardless of enable.
            if (cnt_q == HOLD_LAST) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      // Counter restarts from zero on every state entry and rests in IDLE.
      if (state_d != state_q || state_q == S_IDLE) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // The trigger is registered: it follows the state being entered.
      trigger_d = (state_d == S_TRIG);

      err_count_d = err_count_q;
      if (timeout_d && err_count_q != 8'hFF) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others, independent of block order.
   // NOTE: meas_dist is reset as well; it is a single held register, not a
   // memory, and downstream logic must never see an unknown distance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         trigger_q    <= 1'b0;
         meas_valid_q <= 1'b0;
         meas_dist_q  <= '0;
         timeout_q    <= 1'b0;
         err_count_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         trigger_q    <= trigger_d;
         meas_valid_q <= meas_valid_d;
         meas_dist_q  <= meas_dist_d;
         timeout_q    <= timeout_d;
         err_count_q  <= err_count_d;
      end
   end

   assign trigger    = trigger_q;
   assign meas_valid = meas_valid_q;
   assign meas_dist  = meas_dist_q;
   assign timeout    = timeout_q;
   assign err_count  = err_count_q;
   assign busy       = (state_q != S_IDLE);
   assign seq_state  = state_q;

endmodule

// File: tb/tb_sonar_trigger_seq.sv
// ---------------------------------------------------------------------------
// tb_sonar_trigger_seq
//
// Directed bench for sonar_trigger_seq with small timing parameters
// (TRIG=5, ECHO_TIMEOUT=20, MEAS_TIMEOUT=50, HOLDOFF=10). Inputs change and
// outputs are sampled 1 time unit after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_sonar_trigger_seq;

   localparam int DIS_LEN = 16;
   localparam int TRIG    = 5;
   localparam int ECHO_TO = 20;
   localparam int MEAS_TO = 50;
   localparam int HOLD    = 10;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_TRIG = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_MEAS = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd4;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic              trigger_suc;
   logic              valid;
   logic [DIS_LEN:0]  distance;
   logic              trigger;
   logic              meas_valid;
   logic [DIS_LEN:0]  meas_dist;
   logic              timeout;
   logic [7:0]        err_count;
   logic              busy;
   logic [2:0]        seq_state;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_err  = 0;
   int trig_seen;

   sonar_trigger_seq #(
      .DisLen         (DIS_LEN),
      .TRIG_CYCLES    (TRIG),
      .ECHO_TIMEOUT   (ECHO_TO),
      .MEAS_TIMEOUT   (MEAS_TO),
      .HOLDOFF_CYCLES (HOLD),
      .CNT_W          (22)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .triggerSuc (trigger_suc),
      .valid      (valid),
      .distance   (distance),
      .trigger    (trigger),
      .meas_valid (meas_valid),
      .meas_dist  (meas_dist),
      .timeout    (timeout),
      .err_count  (err_count),
      .busy       (busy),
      .seq_state  (seq_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Advance until seq_state == s, bounded; the final compare fails on expiry.
   task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
      for (int i = 0; i < budget && seq_state != s; i++) tick();
      check(tag, {29'd0, seq_state}, {29'd0, s});
   endtask

   task automatic wait_timeout(input string tag, input int budget);
      for (int i = 0; i < budget && timeout !== 1'b1; i++) tick();
      check(tag, {31'd0, timeout}, 32'd1);
   endtask

   initial begin
      rst         = 1'b1;
      enable      = 1'b1;
      trigger_suc = 1'b0;
      valid       = 1'b0;
      distance    = '0;
      ticks(2);
      check("rst_state",   {29'd0, seq_state}, 32'd0);
      check("rst_trigger", {31'd0, trigger}, 32'd0);
      check("rst_dist",    {15'd0, meas_dist}, 32'd0);
      check("rst_err",     {24'd0, err_count}, 32'd0);
      check("rst_busy",    {31'd0, busy}, 32'd0);
      rst = 1'b0;

      // ---- first attempt: trigger width, successful measurement ----
      tick();
      check("t1_state_trig", {29'd0, seq_state}, {29'd0, ST_TRIG});
      check("t1_trig_hi0",   {31'd0, trigger}, 32'd1);
      for (int i = 1; i < TRIG; i++) begin
         tick();
         check("t1_trig_hi", {31'd0, trigger}, 32'd1);
      end
      tick();
      check("t1_state_wait", {29'd0, seq_state}, {29'd0, ST_WAIT});
      check("t1_trig_lo",    {31'd0, trigger}, 32'd0);
      ticks(3);
      trigger_suc = 1'b1;
      tick();
      trigger_suc = 1'b0;
      check("t1_state_meas", {29'd0, seq_state}, {29'd0, ST_MEAS});
      ticks(7);
      check("t1_still_meas", {29'd0, seq_state}, {29'd0, ST_MEAS});
      valid    = 1'b1;
      distance = 17'h01234;
      tick();
      valid    = 1'b0;
      distance = 17'h1FFFF;
      check("t1_state_hold", {29'd0, seq_state}, {29'd0, ST_HOLD});
      check("t1_mvalid",     {31'd0, meas_valid}, 32'd1);
      check("t1_mdist",      {15'd0, meas_dist}, 32'h01234);
      check("t1_no_to",      {31'd0, timeout}, 32'd0);
      tick();
      check("t1_mvalid_1cy", {31'd0, meas_valid}, 32'd0);
      check("t1_mdist_hold", {15'd0, meas_dist}, 32'h01234);
      ticks(HOLD - 2);
      check("t1_hold_end",   {29'd0, seq_state}, {29'd0, ST_HOLD});
      tick();
      check("t1_idle",       {29'd0, seq_state}, {29'd0, ST_IDLE});
      check("t1_idle_busy",  {31'd0, busy}, 32'd0);
      check("t1_idle_trig",  {31'd0, trigger}, 32'd0);
      tick();
      check("t1_retrig",     {31'd0, trigger}, 32'd1);

      // ---- no echo: WAIT_ECHO timeout after exactly 20 cycles ----
      ticks(TRIG);
      check("t2_wait", {29'd0, seq_state}, {29'd0, ST_WAIT});
      ticks(ECHO_TO - 1);
      check("t2_wait_last", {29'd0, seq_state}, {29'd0, ST_WAIT});
      check("t2_no_to_yet", {31'd0, timeout}, 32'd0);
      tick();
      exp_err++;
      check("t2_hold",   {29'd0, seq_state}, {29'd0, ST_HOLD});
      check("t2_to",     {31'd0, timeout}, 32'd1);
      check("t2_err",    {24'd0, err_count}, exp_err);
      check("t2_no_mv",  {31'd0, meas_valid}, 32'd0);
      check("t2_mdist",  {15'd0, meas_dist}, 32'h01234);
      tick();
      check("t2_to_1cy", {31'd0, timeout}, 32'd0);

      // ---- echo but no result: MEASURE timeout after 50 cycles ----
      wait_state("t3_to_wait", ST_WAIT, 40);
      trigger_suc = 1'b1;
      tick();
      trigger_suc = 1'b0;
      ticks(MEAS_TO - 1);
      check("t3_meas_last", {29'd0, seq_state}, {29'd0, ST_MEAS});
      tick();
      exp_err++;
      check("t3_hold", {29'd0, seq_state}, {29'd0, ST_HOLD});
      check("t3_to",   {31'd0, timeout}, 32'd1);
      check("t3_err",  {24'd0, err_count}, exp_err);

      // ---- valid on the 50th MEASURE cycle wins over the timeout ----
      wait_state("t4_to_wait", ST_WAIT, 40);
      trigger_suc = 1'b1;
      tick();
      trigger_suc = 1'b0;
      ticks(MEAS_TO - 1);
      valid    = 1'b1;
      distance = 17'h1ABCD;
      tick();
      valid = 1'b0;
      check("t4_hold",   {29'd0, seq_state}, {29'd0, ST_HOLD});
      check("t4_mvalid", {31'd0, meas_valid}, 32'd1);
      check("t4_no_to",  {31'd0, timeout}, 32'd0);
      check("t4_mdist",  {15'd0, meas_dist}, 32'h1ABCD);
      check("t4_err",    {24'd0, err_count}, exp_err);

      // ---- triggerSuc on the 20th WAIT_ECHO cycle wins; stray valid in WAIT ignored ----
      wait_state("t5_to_wait", ST_WAIT, 40);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      check("t5_stray_valid", {29'd0, seq_state}, {29'd0, ST_WAIT});
      ticks(ECHO_TO - 2);
      trigger_suc = 1'b1;
      tick();
      trigger_suc = 1'b0;
      check("t5_meas",  {29'd0, seq_state}, {29'd0, ST_MEAS});
      check("t5_no_to", {31'd0, timeout}, 32'd0);
      check("t5_err",   {24'd0, err_count}, exp_err);
      valid    = 1'b1;
      distance = 17'h00042;
      tick();
      valid = 1'b0;
      check("t5_mdist", {15'd0, meas_dist}, 32'h00042);

      // ---- enable dropped in TRIG: full ping, finish attempt, then stop ----
      wait_state("t6_to_trig", ST_TRIG, 40);
      enable = 1'b0;
      check("t6_trig_hi0", {31'd0, trigger}, 32'd1);
      for (int i = 1; i < TRIG; i++) begin
         tick();
         check("t6_trig_hi", {31'd0, trigger}, 32'd1);
      end
      tick();
      check("t6_trig_lo", {31'd0, trigger}, 32'd0);
      wait_timeout("t6_echo_to", 40);
      exp_err++;
      check("t6_err", {24'd0, err_count}, exp_err);
      wait_state("t6_idle", ST_IDLE, 40);
      trig_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (trigger === 1'b1 || seq_state != ST_IDLE) trig_seen++;
      end
      check("t6_no_retrig", trig_seen, 32'd0);

      // ---- 260 consecutive timeouts: err_count saturates at 255 ----
      enable = 1'b1;
      for (int i = 0; i < 260; i++) begin
         wait_timeout("t7_to", 60);
         if (exp_err < 255) exp_err++;
         check("t7_err", {24'd0, err_count}, exp_err);
         tick();
      end
      check("t7_sat", {24'd0, err_count}, 32'd255);

      // ---- asynchronous reset in the middle of TRIG ----
      wait_state("t8_to_trig", ST_TRIG, 60);
      tick();
      check("t8_pre_trig", {31'd0, trigger}, 32'd1);
      #3;
      rst = 1'b1;
      #1;
      check("t8_trig",   {31'd0, trigger}, 32'd0);
      check("t8_state",  {29'd0, seq_state}, 32'd0);
      check("t8_err",    {24'd0, err_count}, 32'd0);
      check("t8_dist",   {15'd0, meas_dist}, 32'd0);
      check("t8_mvalid", {31'd0, meas_valid}, 32'd0);
      check("t8_to",     {31'd0, timeout}, 32'd0);
      check("t8_busy",   {31'd0, busy}, 32'd0);
      enable = 1'b0;
      tick();
      rst = 1'b0;
      ticks(3);
      check("t8_post_trig",  {31'd0, trigger}, 32'd0);
      check("t8_post_state", {29'd0, seq_state}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sonar_trigger_seq.md
Name: sonar_trigger_seq

Overview:
- Measurement sequencer directly upstream of the echo-timing stage in the ultrasonic ranging path.
- Drives the sensor trigger pulse, then waits for the echo-timing stage to report echo start (triggerSuc) and a completed measurement (valid, distance).
- Captures each result, times out lost or absent echoes, and enforces the inter-measurement holdoff against interference.
- Sole source of the sensor trigger line; feeds averaging/display logic downstream.

Parameters:
- DisLen, 16, echo-timing stage distance MSB index; distance buses are DisLen+1 bits.
- TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz).
- ECHO_TIMEOUT, 1500000, max cycles in WAIT_ECHO before giving up (30 ms).
- MEAS_TIMEOUT, 131088, max cycles in MEASURE (2^(DisLen+1)+16).
- HOLDOFF_CYCLES, 2500000, idle spacing after every attempt (50 ms).
- CNT_W, 22, internal counter width; must hold every timing parameter above.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; high = run measurements back to back
- triggerSuc  in  1  one-cycle pulse from echo-timing stage: echo rose
- valid  in  1  one-cycle pulse from echo-timing stage: distance valid
- distance  in  DisLen+1  echo width in cycles, sampled when valid=1
- trigger  out  1  sensor trigger, registered
- meas_valid  out  1  one-cycle pulse: meas_dist updated
- meas_dist  out  DisLen+1  last captured distance, held
- timeout  out  1  one-cycle pulse: attempt failed
- err_count  out  8  saturating count of timeouts
- busy  out  1  high in any state other than IDLE
- seq_state  out  3  state encoding for testing: IDLE=0, TRIG=1, WAIT_ECHO=2, MEASURE=3, HOLDOFF=4

Behaviour:
- Reset (async, immediate): state IDLE, counter 0, trigger 0, meas_valid 0, meas_dist 0, timeout 0, err_count 0. Reset mid-cycle drops trigger at once; no pulse is emitted on release.
- All outputs are registered. Counter clears on every state entry.
- IDLE:
  - enable=1 sampled -> TRIG next edge; trigger=1 from that edge.
  - enable=0 -> stay.
- TRIG:
  - trigger held high for exactly TRIG_CYCLES cycles.
  - At counter=TRIG_CYCLES-1 -> WAIT_ECHO; trigger low from that edge.
  - triggerSuc/valid are ignored here.
- WAIT_ECHO:
  - triggerSuc=1 -> MEASURE.
  - Otherwise, at counter=ECHO_TIMEOUT-1 -> HOLDOFF with timeout pulse.
  - triggerSuc on the timeout cycle wins: go to MEASURE, no timeout.
  - A stray valid is ignored.
- MEASURE:
  - valid=1 -> meas_dist<=distance, meas_valid=1 for one cycle, then HOLDOFF.
  - Otherwise, at counter=MEAS_TIMEOUT-1 -> HOLDOFF with timeout pulse.
  - This covers the echo stage saturating and returning without valid.
  - valid on the timeout cycle wins.
- HOLDOFF:
  - Count HOLDOFF_CYCLES cycles, then IDLE.
  - Always completes, whatever enable does.
  - triggerSuc/valid are ignored.
- Timeout pulse: err_count increments, saturating at 255 (no wrap).
- Dropping enable mid-attempt finishes the current attempt through HOLDOFF, then stays IDLE.
- Period with enable held high and a successful echo: TRIG_CYCLES + wait + measure + HOLDOFF_CYCLES + 1 (IDLE cycle).
- meas_dist is never cleared except by reset.

Test Plan (sim params: TRIG_CYCLES=5, ECHO_TIMEOUT=20, MEAS_TIMEOUT=50, HOLDOFF_CYCLES=10, DisLen=16):
- enable=1 from reset release -> trigger high exactly 5 cycles starting 1 edge after enable sampled; seq_state 0->1->2.
- triggerSuc 3 cycles into WAIT_ECHO; valid with distance=17'h01234 8 cycles later -> meas_valid 1 cycle; meas_dist=17'h01234; HOLDOFF 10 cycles; next trigger rises 11 cycles after HOLDOFF entry.
- No triggerSuc -> timeout pulse after 20 WAIT_ECHO cycles; err_count=1; no meas_valid; meas_dist unchanged.
- triggerSuc with no valid -> timeout after 50 MEASURE cycles. Separately, valid on the exact 50th cycle -> meas_valid=1, timeout=0.
- enable dropped during TRIG -> trigger still 5 cycles; sequence runs through HOLDOFF to IDLE; no further trigger.
- 256 consecutive timeouts -> err_count stays 255.
- rst asserted mid-TRIG -> trigger 0 immediately, all outputs at reset values.
